// File: rtl/snn_inference_sequencer.sv
// Launch/stream/drain/result sequencer in front of the three-layer SNN pipeline.
// Define SNN_SEQ_WATCHDOG_EN to build the watchdog, FLUSH soft reset and o_timeout.
module snn_inference_sequencer #(
  parameter int IN_NEURONS     = 320,
  parameter int ADDR_W         = 9,
  parameter int TIME_W         = 32,
  parameter int CLASS_W        = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FLUSH_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  output logic               o_ready,
  output logic               o_busy,
  input  logic               i_src_valid,
  input  logic [TIME_W-1:0]  i_src_time,
  input  logic [ADDR_W-1:0]  i_src_addr,
  input  logic               i_src_last,
  output logic               o_src_ack,
  output logic               o_cnn_spike_valid,
  output logic [TIME_W-1:0]  o_cnn_spike_time,
  output logic [ADDR_W-1:0]  o_cnn_spike_addr,
  output logic               o_cnn_last_pixel_sent,
  input  logic               i_cnn_spike_ack,
  input  logic               i_inference_done,
  input  logic [CLASS_W-1:0] i_predicted_class,
  output logic               o_result_valid,
  output logic [CLASS_W-1:0] o_result_class,
  input  logic               i_result_ack,
  output logic               o_timeout,
  output logic               o_addr_err,
  output logic [9:0]         o_spike_count,
  output logic [CNT_W-1:0]   o_cycle_count,
  output logic               o_snn_rst_n
);

  // state  | meaning
  // IDLE   | waiting for i_start, o_ready high
  // STREAM | spikes passed through to the pipeline
  // DRAIN  | last spike sent, waiting for inference done
  // DONE   | result held until i_result_ack
  // FLUSH  | pipeline soft reset after a watchdog expiry
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE, S_FLUSH} state_t;

`ifdef SNN_SEQ_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam int               FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(FLUSH_CYCLES - 1);

  state_t             r_state;
  logic [9:0]         r_spike_cnt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic               r_result_valid;
  logic [CLASS_W-1:0] r_result_class;
  logic               r_timeout;
  logic               r_addr_err;
  logic               r_snn_rst_n;
  logic [FL_W-1:0]    r_flush_cnt;

  logic w_stream;
  logic w_busy;
  logic w_in_range;
  logic w_fwd;
  logic w_xfer;
  logic w_drop;
  logic w_last_seen;
  logic w_wdog_go;

  // Extra MSB keeps the range compare correct even when IN_NEURONS == 2**ADDR_W.
  assign w_in_range  = ({1'b0, i_src_addr} < (ADDR_W+1)'(IN_NEURONS));
  assign w_stream    = (r_state == S_STREAM);
  assign w_busy      = w_stream || (r_state == S_DRAIN);
  assign w_fwd       = w_stream && w_in_range;
  assign w_xfer      = w_fwd && i_src_valid && i_cnn_spike_ack;
  assign w_drop      = w_stream && !w_in_range && i_src_valid;
  assign w_last_seen = (w_xfer || w_drop) && i_src_last;
  assign w_wdog_go   = WDOG_EN && w_busy && (r_cycle_cnt == TO_LAST);

  assign o_ready               = (r_state == S_IDLE);
  assign o_busy                = w_busy;
  assign o_cnn_spike_valid     = w_fwd && i_src_valid;
  assign o_cnn_spike_time      = w_fwd ? i_src_time : '0;
  assign o_cnn_spike_addr      = w_fwd ? i_src_addr : '0;
  assign o_cnn_last_pixel_sent = w_fwd && i_src_valid && i_src_last;
  assign o_src_ack             = w_stream && (w_in_range ? i_cnn_spike_ack : 1'b1);

  assign o_result_valid = r_result_valid;
  assign o_result_class = r_result_class;
  assign o_addr_err     = r_addr_err;
  assign o_spike_count  = r_spike_cnt;
  assign o_cycle_count  = r_cycle_cnt;
  assign o_timeout      = WDOG_EN ? r_timeout : 1'b0;
  assign o_snn_rst_n    = WDOG_EN ? r_snn_rst_n : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_spike_cnt    <= '0;
      r_cycle_cnt    <= '0;
      r_result_valid <= 1'b0;
      r_result_class <= '0;
      r_timeout      <= 1'b0;
      r_addr_err     <= 1'b0;
      r_snn_rst_n    <= 1'b1;
      r_flush_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_STREAM;
            r_spike_cnt <= '0;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
            r_addr_err  <= 1'b0;
          end
        end
        S_STREAM, S_DRAIN: begin
          if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          if (w_xfer && (r_spike_cnt != '1)) r_spike_cnt <= r_spike_cnt + 10'd1;
          if (w_drop) r_addr_err <= 1'b1;
          // Done outranks the watchdog when both land on the same cycle.
          if (i_inference_done) begin
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
            r_result_class <= i_predicted_class;
          end else if (w_wdog_go) begin
            r_state     <= S_FLUSH;
            r_timeout   <= 1'b1;
            r_snn_rst_n <= 1'b0;
            r_flush_cnt <= FL_LOAD;
          end else if (w_last_seen) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (i_result_ack) begin
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_snn_rst_n <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - FL_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed scoreboard bench for snn_inference_sequencer (watchdog checks follow SNN_SEQ_WATCHDOG_EN).
module tb_snn_inference_sequencer;
  localparam int IN_NEURONS = 320;
  localparam int ADDR_W     = 9;
  localparam int TIME_W     = 32;
  localparam int CLASS_W    = 2;
  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 2000;
  localparam int FLUSH      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic o_ready, o_busy;
  logic i_src_valid = 1'b0;
  logic [TIME_W-1:0] i_src_time = '0;
  logic [ADDR_W-1:0] i_src_addr = '0;
  logic i_src_last = 1'b0;
  logic o_src_ack;
  logic o_cnn_spike_valid;
  logic [TIME_W-1:0] o_cnn_spike_time;
  logic [ADDR_W-1:0] o_cnn_spike_addr;
  logic o_cnn_last_pixel_sent;
  logic i_cnn_spike_ack = 1'b0;
  logic i_inference_done = 1'b0;
  logic [CLASS_W-1:0] i_predicted_class = '0;
  logic o_result_valid;
  logic [CLASS_W-1:0] o_result_class;
  logic i_result_ack = 1'b0;
  logic o_timeout, o_addr_err;
  logic [9:0] o_spike_count;
  logic [CNT_W-1:0] o_cycle_count;
  logic o_snn_rst_n;

  snn_inference_sequencer #(
    .IN_NEURONS(IN_NEURONS), .ADDR_W(ADDR_W), .TIME_W(TIME_W), .CLASS_W(CLASS_W),
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_ready(o_ready), .o_busy(o_busy),
    .i_src_valid(i_src_valid), .i_src_time(i_src_time), .i_src_addr(i_src_addr),
    .i_src_last(i_src_last), .o_src_ack(o_src_ack),
    .o_cnn_spike_valid(o_cnn_spike_valid), .o_cnn_spike_time(o_cnn_spike_time),
    .o_cnn_spike_addr(o_cnn_spike_addr), .o_cnn_last_pixel_sent(o_cnn_last_pixel_sent),
    .i_cnn_spike_ack(i_cnn_spike_ack), .i_inference_done(i_inference_done),
    .i_predicted_class(i_predicted_class), .o_result_valid(o_result_valid),
    .o_result_class(o_result_class), .i_result_ack(i_result_ack), .o_timeout(o_timeout),
    .o_addr_err(o_addr_err), .o_spike_count(o_spike_count), .o_cycle_count(o_cycle_count),
    .o_snn_rst_n(o_snn_rst_n)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TIME_W-1:0] t;
    logic              last;
  } spk_t;

  spk_t               sq[$];
  logic [CLASS_W-1:0] res_q[$];
  int checks = 0;
  int failures = 0;
  int unsigned start_edge = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_n;
    i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_ready", o_ready, 0);
    chk("start_spike_cnt", o_spike_count, 0);
    chk("start_cycle_cnt", o_cycle_count, 0);
    chk("start_addr_err", o_addr_err, 0);
    chk("start_timeout", o_timeout, 0);
  endtask

  // Source side: spikes idx 0..n-1, addr=idx (400 at bad_at), last on n-1.
  // ack_mode 0: pipeline acks every cycle; 1: acks one cycle in four.
  task automatic stream(input int n, input int bad_at, input int ack_mode);
    int   idx = 0;
    int   cyc = 0;
    spk_t e;
    logic [ADDR_W-1:0] a;
    while (idx < n && cyc < 4 * n + 20) begin
      a = (idx == bad_at) ? ADDR_W'(400) : ADDR_W'(idx);
      i_src_valid     = 1'b1;
      i_src_addr      = a;
      i_src_time      = TIME_W'(idx * 3 + 7);
      i_src_last      = (idx == n - 1);
      i_cnn_spike_ack = (ack_mode == 0) || (cyc % 4 == 3);
      @(negedge clk);
      if (o_src_ack) begin
        if (idx != bad_at) sq.push_back('{addr: a, t: i_src_time, last: i_src_last});
        idx++;
      end
      if (o_cnn_spike_valid && i_cnn_spike_ack) begin
        checks++;
        assert (sq.size() != 0) else begin
          failures++;
          $error("FAIL spk_unexpected observed_addr=%0d expected=none", o_cnn_spike_addr);
        end
        if (sq.size() != 0) begin
          e = sq.pop_front();
          chk("spk_addr", o_cnn_spike_addr, e.addr);
          chk("spk_time", o_cnn_spike_time, e.t);
          chk("spk_last", o_cnn_last_pixel_sent, e.last);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i_src_valid     = 1'b0;
    i_src_last      = 1'b0;
    i_cnn_spike_ack = 1'b0;
    chk("stream_all_accepted", idx, n);
    chk("spk_queue_empty", sq.size(), 0);
  endtask

  task automatic finish_done(input logic [CLASS_W-1:0] cls);
    logic [CLASS_W-1:0] e;
    i_inference_done  = 1'b1;
    i_predicted_class = cls;
    res_q.push_back(cls);
    @(posedge clk);
    #1;
    i_inference_done  = 1'b0;
    i_predicted_class = cls + 2'd1;
    chk("res_valid", o_result_valid, 1);
    chk("res_busy_off", o_busy, 0);
    e = res_q.pop_front();
    chk("res_class", o_result_class, e);
    i_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("done_start_ignored", o_busy, 0);
    chk("res_hold_valid", o_result_valid, 1);
    chk("res_hold_class", o_result_class, e);
    i_result_ack = 1'b1;
    @(posedge clk);
    #1;
    i_result_ack = 1'b0;
    chk("ack_ready", o_ready, 1);
    chk("ack_valid_clr", o_result_valid, 0);
    chk("ack_class_kept", o_result_class, e);
  endtask

  initial begin
    int w;
    int low;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_snn_rst_n", o_snn_rst_n, 1);
    chk("rst_result_valid", o_result_valid, 0);
    chk("rst_result_class", o_result_class, 0);
    chk("rst_spike_cnt", o_spike_count, 0);
    chk("rst_cycle_cnt", o_cycle_count, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_addr_err", o_addr_err, 0);
    chk("rst_src_ack", o_src_ack, 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal run
    do_start();
    stream(IN_NEURONS, -1, 0);
    chk("nom_spike_cnt", o_spike_count, IN_NEURONS);
    chk("nom_drain_busy", o_busy, 1);
    repeat (40) @(posedge clk);
    #1;
    finish_done(2'd2);
    chk("nom_cycle_cnt", o_cycle_count, IN_NEURONS + 40 + 1);

    // Backpressure
    do_start();
    stream(IN_NEURONS, -1, 1);
    chk("bp_spike_cnt", o_spike_count, IN_NEURONS);
    finish_done(2'd1);

    // Out-of-range address mid-stream
    do_start();
    stream(20, 7, 0);
    chk("bad_addr_err", o_addr_err, 1);
    chk("bad_spike_cnt", o_spike_count, 19);
    finish_done(2'd1);

    // Out-of-range address carrying last: DRAIN, forwarding off
    do_start();
    stream(6, 5, 0);
    chk("badlast_drain", o_busy, 1);
    chk("badlast_err", o_addr_err, 1);
    chk("badlast_cnt", o_spike_count, 5);
    i_src_valid = 1'b1;
    i_src_addr = ADDR_W'(3);
    i_cnn_spike_ack = 1'b1;
    i_start = 1'b1;
    #1;
    chk("drain_no_ack", o_src_ack, 0);
    chk("drain_no_fwd", o_cnn_spike_valid, 0);
    @(posedge clk);
    #1;
    i_src_valid = 1'b0;
    i_cnn_spike_ack = 1'b0;
    i_start = 1'b0;
    chk("drain_start_ignored", o_busy, 1);
    finish_done(2'd0);

    // Watchdog
    do_start();
    stream(10, -1, 0);
`ifdef SNN_SEQ_WATCHDOG_EN
    w = 0;
    while (o_snn_rst_n && w < TIMEOUT + 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("wdog_edge", edge_n - start_edge, TIMEOUT);
    chk("wdog_timeout", o_timeout, 1);
    chk("wdog_busy_off", o_busy, 0);
    low = 0;
    while (!o_snn_rst_n && low < 20) begin
      chk("flush_no_result", o_result_valid, 0);
      low++;
      @(posedge clk);
      #1;
    end
    chk("flush_len", low, FLUSH);
    chk("flush_ready", o_ready, 1);
    chk("flush_timeout_sticky", o_timeout, 1);
    chk("flush_class_kept", o_result_class, 0);
`else
    repeat (TIMEOUT + 100) @(posedge clk);
    #1;
    chk("nowdog_still_busy", o_busy, 1);
    chk("nowdog_timeout", o_timeout, 0);
    chk("nowdog_snn_rst_n", o_snn_rst_n, 1);
    chk("nowdog_cycle_sat_free", o_cycle_count, TIMEOUT + 100 + 10);
    finish_done(2'd1);
`endif

    // Done and watchdog decision on the same cycle
    do_start();
    stream(4, -1, 0);
    w = 0;
    while (o_cycle_count != CNT_W'(TIMEOUT - 1) && w < TIMEOUT + 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("corner_reach", o_cycle_count, TIMEOUT - 1);
    finish_done(2'd3);
    chk("corner_timeout", o_timeout, 0);
    chk("corner_snn_rst_n", o_snn_rst_n, 1);

    // Reset mid-stream
    do_start();
    for (int k = 0; k < 3; k++) begin
      i_src_valid = 1'b1;
      i_src_addr = ADDR_W'(k);
      i_src_time = TIME_W'(k);
      i_cnn_spike_ack = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_cnt", o_spike_count, 3);
    chk("pre_rst_fwd", o_cnn_spike_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_src_ack", o_src_ack, 0);
    chk("mid_rst_fwd", o_cnn_spike_valid, 0);
    chk("mid_rst_addr", o_cnn_spike_addr, 0);
    chk("mid_rst_spike_cnt", o_spike_count, 0);
    chk("mid_rst_cycle_cnt", o_cycle_count, 0);
    chk("mid_rst_class", o_result_class, 0);
    chk("mid_rst_snn_rst_n", o_snn_rst_n, 1);
    i_src_valid = 1'b0;
    i_cnn_spike_ack = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", o_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=still_running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
